// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ requesters,
// latching one byte per grant and sequencing start/busy/done for that frame.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data,
   input  logic [NUM_REQ-1:0]            req_parity_en,
   input  logic [NUM_REQ-1:0]            req_even_parity,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            req_done,
   output logic [DATA_W-1:0]             data_in,
   output logic                          parity_en,
   output logic                          even_parity,
   output logic                          tx_start,
   input  logic                          tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          arb_busy,
   output logic                          timeout_err
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            state, next_state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   scan_idx;
   logic              grant_valid;
   logic [CNT_W-1:0]  wait_cnt;
   logic              timeout_hit;
   logic              frame_done;

   // Wrap is an explicit compare so non-power-of-two NUM_REQ never lands on an unused index.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan_idx    = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + 1'b1;
         if (!grant_valid && req_valid[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
      end
      if (state != IDLE || tx_busy || !rst_n) begin
         grant_valid = 1'b0;
         grant_idx   = '0;
      end
   end

   assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (wait_cnt == CNT_LAST);
   assign frame_done  = ((state == WAIT_DONE) && !tx_busy) || timeout_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:      if (grant_valid) next_state = START;
         START:     next_state = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy) begin
               next_state = WAIT_DONE;
            end else if (timeout_hit) begin
               next_state = IDLE;
            end
         end
         WAIT_DONE: if (!tx_busy) next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = '0;
      req_done    = '0;
      tx_start    = (state == START);
      arb_busy    = (state != IDLE);
      timeout_err = timeout_hit;
      if (grant_valid) req_ready[grant_idx] = 1'b1;
      if (frame_done)  req_done[grant_id]   = 1'b1;
   end

   // Frame fields only change on a grant edge, so they stay stable for the whole frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_in     <= '0;
         parity_en   <= 1'b0;
         even_parity <= 1'b0;
         grant_id    <= '0;
         rr_ptr      <= LAST_ID;
         wait_cnt    <= '0;
      end else begin
         if (grant_valid) begin
            data_in     <= req_data[int'(grant_idx) * DATA_W +: DATA_W];
            parity_en   <= req_parity_en[grant_idx];
            even_parity <= req_even_parity[grant_idx];
            grant_id    <= grant_idx;
            rr_ptr      <= grant_idx;
         end
         if (state == START) begin
            wait_cnt <= '0;
         end else if (state == WAIT_BUSY && !tx_busy && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table with a directly driven tx_busy, plus
// sequences against a small behavioral uart_tx for frames, fairness and reset.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_parity_en;
   logic [3:0]  req_even_parity;
   logic [3:0]  req_ready;
   logic [3:0]  req_done;
   logic [7:0]  data_in;
   logic        parity_en;
   logic        even_parity;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        timeout_err;

   logic        use_model;
   logic        forced_busy;
   logic        m_busy;
   logic [10:0] m_frame;
   int          m_pos;
   int          m_len;
   logic        tx_line;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] valid;
      logic       busy;
      logic [3:0] ready;
      logic       start;
      logic [3:0] done;
      logic       arb;
      logic       tmo;
      logic [1:0] gid;
      logic [7:0] data;
   } vec_t;

   vec_t vecs [24];

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_parity_en   (req_parity_en),
      .req_even_parity (req_even_parity),
      .req_ready       (req_ready),
      .req_done        (req_done),
      .data_in         (data_in),
      .parity_en       (parity_en),
      .even_parity     (even_parity),
      .tx_start        (tx_start),
      .tx_busy         (tx_busy),
      .grant_id        (grant_id),
      .arb_busy        (arb_busy),
      .timeout_err     (timeout_err)
   );

   always #5 clk = ~clk;

   // Behavioral uart_tx: one bit per cycle, busy for exactly the frame length.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_pos  <= 0;
      end else if (m_busy) begin
         if (m_pos == m_len - 1) m_busy <= 1'b0;
         else m_pos <= m_pos + 1;
      end else if (use_model && tx_start) begin
         m_busy  <= 1'b1;
         m_pos   <= 0;
         m_len   <= parity_en ? 11 : 10;
         m_frame <= parity_en ? {1'b1, (even_parity ? ^data_in : ~^data_in), data_in, 1'b0}
                              : {2'b11, data_in, 1'b0};
      end
   end

   assign tx_busy = use_model ? m_busy : forced_busy;
   assign tx_line = m_busy ? m_frame[m_pos] : 1'b1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      req_valid   = 4'b0000;
      use_model   = 1'b0;
      forced_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_output("reset arb_busy",    32'(arb_busy),    32'h0);
      check_output("reset tx_start",    32'(tx_start),    32'h0);
      check_output("reset req_ready",   32'(req_ready),   32'h0);
      check_output("reset req_done",    32'(req_done),    32'h0);
      check_output("reset timeout_err", 32'(timeout_err), 32'h0);
      check_output("reset grant_id",    32'(grant_id),    32'h0);
      check_output("reset data_in",     32'(data_in),     32'h0);
      check_output("reset parity",      32'({parity_en, even_parity}), 32'h0);
      rst_n = 1'b1;
   endtask

   task automatic apply_stimulus(input int i);
      @(negedge clk);
      req_valid   = vecs[i].valid;
      forced_busy = vecs[i].busy;
      #1;
      check_output($sformatf("v%0d req_ready", i),   32'(req_ready),   32'(vecs[i].ready));
      check_output($sformatf("v%0d tx_start", i),    32'(tx_start),    32'(vecs[i].start));
      check_output($sformatf("v%0d req_done", i),    32'(req_done),    32'(vecs[i].done));
      check_output($sformatf("v%0d arb_busy", i),    32'(arb_busy),    32'(vecs[i].arb));
      check_output($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].tmo));
      check_output($sformatf("v%0d grant_id", i),    32'(grant_id),    32'(vecs[i].gid));
      check_output($sformatf("v%0d data_in", i),     32'(data_in),     32'(vecs[i].data));
   endtask

   // Holds valid high and records grants; order packs 2-bit requester ids, first grant in the LSBs.
   task automatic run_order(input logic [3:0] valid, input int n, input logic [15:0] order, input string tag);
      int got = 0;
      int cyc = 0;
      logic [1:0] g;
      use_model = 1'b1;
      req_valid = valid;
      while (got < n && cyc < 600) begin
         #1;
         if (req_ready != 4'b0000) begin
            g = order[got*2 +: 2];
            check_output($sformatf("%s grant%0d ready", tag, got), 32'(req_ready), 32'(4'b0001 << g));
            @(negedge clk);
            #1;
            check_output($sformatf("%s grant%0d tx_start", tag, got), 32'(tx_start), 32'h1);
            check_output($sformatf("%s grant%0d grant_id", tag, got), 32'(grant_id), 32'(g));
            check_output($sformatf("%s grant%0d data_in", tag, got), 32'(data_in), 32'(req_data[g*8 +: 8]));
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      check_output($sformatf("%s grants seen", tag), 32'(got), 32'(n));
      req_valid = 4'b0000;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [10:0] exp_frame;
      int waited;

      //          valid    busy  ready    start done     arb   tmo   gid    data
      vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
      vecs[1]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
      vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
      vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h33};
      vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h33};
      vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h33};
      vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 8'h33};
      vecs[7]  = '{4'b1011, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h33};
      vecs[8]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 8'h44};
      vecs[9]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 8'h44};
      vecs[10] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 8'h44};
      vecs[11] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 8'h44};
      vecs[12] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h44};
      vecs[13] = '{4'b1011, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h44};
      vecs[14] = '{4'b1011, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h11};
      vecs[15] = '{4'b1011, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h11};
      vecs[16] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 8'h11};
      vecs[17] = '{4'b1011, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h11};
      vecs[18] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 8'h22};
      vecs[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 8'h22};
      vecs[20] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1, 8'h22};
      vecs[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h22};
      vecs[22] = '{4'b1000, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h22};
      vecs[23] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 8'h44};

      req_data        = {8'h44, 8'h33, 8'h22, 8'h11};
      req_parity_en   = 4'b0101;
      req_even_parity = 4'b0011;
      do_reset();
      for (int i = 0; i < 24; i++) apply_stimulus(i);

      // Single 0xA5 frame with even parity through the uart_tx model.
      req_data        = {8'h44, 8'hA5, 8'h22, 8'h11};
      req_parity_en   = 4'b0100;
      req_even_parity = 4'b0100;
      do_reset();
      use_model = 1'b1;
      req_valid = 4'b0100;
      #1;
      check_output("single req_ready", 32'(req_ready), 32'h4);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check_output("single tx_start", 32'(tx_start), 32'h1);
      check_output("single latched", 32'({grant_id, parity_en, even_parity, data_in}), 32'({2'd2, 1'b1, 1'b1, 8'hA5}));
      exp_frame = 11'b1_0_10100101_0;
      for (int b = 0; b < 11; b++) begin
         @(negedge clk);
         #1;
         check_output($sformatf("single tx bit%0d", b), 32'(tx_line), 32'(exp_frame[b]));
      end
      waited = 0;
      while (req_done == 4'b0000 && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check_output("single done latency", 32'(waited), 32'h1);
      check_output("single req_done", 32'(req_done), 32'h4);
      check_output("single grant_id", 32'(grant_id), 32'h2);
      @(negedge clk);
      #1;
      check_output("single done width", 32'({req_done, arb_busy}), 32'h0);

      req_data        = {8'h44, 8'h33, 8'h22, 8'h11};
      req_parity_en   = 4'b0000;
      req_even_parity = 4'b0000;
      do_reset();
      run_order(4'b1011, 6, 16'h0D34, "simul");
      do_reset();
      run_order(4'b1111, 8, 16'hE4E4, "fair");

      // Abort during the data bits, then confirm priority restarts at requester 0.
      do_reset();
      use_model = 1'b1;
      req_valid = 4'b0100;
      waited = 0;
      while (!tx_start && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check_output("abort tx_start seen", 32'(tx_start), 32'h1);
      req_valid = 4'b0000;
      repeat (4) @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 4'b0101;
      @(negedge clk);
      #1;
      check_output("abort tx_start", 32'(tx_start), 32'h0);
      check_output("abort req_ready", 32'(req_ready), 32'h0);
      check_output("abort req_done", 32'(req_done), 32'h0);
      check_output("abort arb_busy", 32'(arb_busy), 32'h0);
      check_output("abort grant_id", 32'(grant_id), 32'h0);
      rst_n = 1'b1;
      #1;
      check_output("abort first ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      #1;
      check_output("abort restart", 32'({tx_start, grant_id}), 32'({1'b1, 2'd0}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx transmitter among NUM_REQ requesters.
- Each requester hands over one byte plus its parity configuration through a valid/ready handshake.
- The arbiter sequences one uart_tx frame per grant and reports completion back to that requester.
- Sits between the requesting blocks and the uart_tx instance; drives every uart_tx input except clk and rst_n.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must equal the uart_tx data_in width.
- BUSY_TIMEOUT, 4, maximum cycles to wait for tx_busy to rise after tx_start before declaring an error.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request.
- req_data  input  NUM_REQ*DATA_W  flattened bytes; requester i uses bits [i*DATA_W +: DATA_W].
- req_parity_en  input  NUM_REQ  per-requester parity enable.
- req_even_parity  input  NUM_REQ  per-requester parity select (1 = even).
- req_ready  output  NUM_REQ  one-hot acceptance; the transfer occurs when valid & ready.
- req_done  output  NUM_REQ  one-cycle pulse when that requester's frame finishes.
- data_in  output  DATA_W  to uart_tx.
- parity_en  output  1  to uart_tx.
- even_parity  output  1  to uart_tx.
- tx_start  output  1  to uart_tx; one-cycle pulse.
- tx_busy  input  1  from uart_tx.
- grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester.
- arb_busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse on BUSY_TIMEOUT expiry.

Behaviour:
- Reset values (rst_n=0 at a clock edge): state=IDLE, tx_start=0, data_in=0, parity_en=0, even_parity=0, req_ready=0, req_done=0, timeout_err=0, grant_id=0, rr_ptr=NUM_REQ-1.
  - With rr_ptr=NUM_REQ-1, requester 0 has top priority first.
- States and transitions:
  - IDLE: the combinational grant is the first i with req_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
    - Grant is only given when tx_busy=0. If tx_busy=1, no grant and req_ready=0.
    - In the grant cycle req_ready[g]=1 (exactly one bit), combinationally.
    - At the clock edge the arbiter registers req_data/parity_en/even_parity of g into data_in/parity_en/even_parity, sets grant_id=g, rr_ptr=g, and goes to START.
    - No valid requester: stay in IDLE.
  - START: tx_start=1 for exactly this one cycle. Next state is WAIT_BUSY and the timeout counter is cleared.
  - WAIT_BUSY: tx_busy=1 moves to WAIT_DONE.
    - Otherwise the counter increments.
    - When the counter reaches BUSY_TIMEOUT: timeout_err pulses 1 cycle, req_done[grant_id] pulses, state goes to IDLE.
  - WAIT_DONE: the cycle tx_busy is sampled 0, req_done[grant_id]=1 for one cycle and state goes to IDLE.
- Stability: data_in, parity_en and even_parity hold their latched values from the grant edge until the next grant.
  - They are never changed while arb_busy=1.
- Request stability: requesters may change req_data/req_valid freely while not granted. Only the grant-cycle values are used.
- A requester whose req_valid stays high after acceptance is treated as a new request. Round-robin prevents it starving the others.
- Throughput: minimum one IDLE cycle between req_done and the next tx_start.
  - Grant-to-tx_start latency is 1 cycle.
- Simultaneous req_valid deassert in the grant cycle: the combinational grant already excludes it, so no transfer happens for that requester.
- Reset mid-frame: rst_n=0 aborts immediately; all outputs go to reset values on that edge.
  - No req_done is issued for the aborted frame.
  - uart_tx is reset by the same rst_n.
- NUM_REQ not a power of two: rr_ptr wrap uses explicit compare to NUM_REQ-1, not bit truncation.

Test Plan:
- Single request: req_valid[2]=1, data 0xA5, parity_en=1, even=1 → req_ready[2] 1 cycle; tx_start 1 cycle later.
  - Required tx bits: start 0, then 1,0,1,0,0,1,0,1 (LSB first), parity 0, stop 1.
  - req_done[2] pulses the cycle after tx_busy falls; grant_id=2.
- Simultaneous: req_valid=4'b1011 held after reset → grant order 0,1,3,0,1,3…; each frame's data_in matches its requester.
- Fairness: all four valid continuously for 8 frames → exactly 2 grants each, order 0,1,2,3,0,1,2,3.
- Timeout: tx_busy forced 0 → timeout_err pulses exactly 4 cycles after tx_start; req_done pulses; arbiter returns to IDLE and serves the next requester.
- Busy gate: tx_busy=1 while IDLE with req_valid=1 → req_ready stays 0 until tx_busy=0.
- Reset mid-frame: rst_n=0 during the data bits → next edge tx_start=0, req_ready=0, req_done=0, arb_busy=0; after release, requester 0 is granted first.
